prog_ctr_unit: RTL and testbench

Program-counter and branch-target stage that sits directly upstream of the instruction ROM and the datapath in the top-level DUT.
- Produces the fetch address prog_ct every cycle.
- Applies sequential, relative and LUT-based absolute branches.
- Owns generation of the top-level done flag on a halt instruction or on an out-of-range fetch.
- Control inputs come from the decoder; the branch-taken decision comes from the ALU flag path.

---
 rtl/prog_ctr_unit.sv | 112 +++++++++++
 tb/tb_prog_ctr_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_ctr_unit.sv
// Program counter with sequential, relative and LUT-absolute branches.
// Raises done on halt or on an out-of-range next address (pc_fault).
module prog_ctr_unit #(
    parameter int PC_W     = 10,
    parameter int PROG_LEN = 1024,
    parameter int LUT_AW   = 5
) (
    input  logic              clk,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_en,
    input  logic              branch_taken,
    input  logic              branch_abs,
    input  logic [LUT_AW-1:0] lut_idx,
    input  logic [7:0]        rel_off,
    input  logic              halt,
    input  logic              lut_wen,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [PC_W-1:0]   lut_wdata,
    output logic [PC_W-1:0]   prog_ct,
    output logic              done,
    output logic              pc_fault
);

    // Two bits of headroom: a sign bit plus one so prog_ct + 127 never wraps.
    localparam int              NW    = PC_W + 2;
    localparam logic [NW-1:0]   LEN_N = NW'(PROG_LEN);

    typedef enum logic {
        RUN,
        DONE
    } state_t;

    state_t            state, state_d;
    logic [PC_W-1:0]   pc_d;
    logic              done_d;
    logic              fault_d;

    logic [PC_W-1:0]   lut [2**LUT_AW];
    logic [NW-1:0]     next_pc;
    logic              next_fault;
    logic              take;

    // NOTE: no reset on the LUT; it is plain storage that must survive start.
    always_ff @(posedge clk) begin
        if (lut_wen) begin
            lut[lut_waddr] <= lut_wdata;
        end
    end

    assign take = branch_en && branch_taken;

    always_comb begin
        next_pc = NW'(prog_ct) + NW'(1);
        if (take) begin
            if (branch_abs) begin
                next_pc = NW'(lut[lut_idx]);
            end else begin
                next_pc = NW'(prog_ct) + {{(NW-8){rel_off[7]}}, rel_off};
            end
        end
    end

    // Negative results have the top bit set, so one unsigned compare covers both ends.
    assign next_fault = (next_pc >= LEN_N);

    // NOTE: every output of this block is defaulted first so no latch is inferred.
    always_comb begin
        state_d = state;
        pc_d    = prog_ct;
        done_d  = done;
        fault_d = pc_fault;
        case (state)
            RUN: begin
                if (!stall) begin
                    if (halt) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (next_fault) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = next_pc[PC_W-1:0];
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = DONE;
            end
        endcase
    end

    // NOTE: registers use non-blocking assignment so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (start) begin
            state    <= RUN;
            prog_ct  <= '0;
            done     <= 1'b0;
            pc_fault <= 1'b0;
        end else begin
            state    <= state_d;
            prog_ct  <= pc_d;
            done     <= done_d;
            pc_fault <= fault_d;
        end
    end

endmodule

// File: tb/tb_prog_ctr_unit.sv
// Bench for prog_ctr_unit: directed scenarios plus random traffic, two instances
// (PROG_LEN 1024 and 16) compared each cycle against an integer reference model.
module tb_prog_ctr_unit;

    logic       clk;
    logic       start, stall, branch_en, branch_taken, branch_abs, halt, lut_wen;
    logic [4:0] lut_idx, lut_waddr;
    logic [7:0] rel_off;
    logic [9:0] lut_wdata;
    logic [9:0] pc_a, pc_b;
    logic       done_a, done_b, fault_a, fault_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int pc;
        bit done;
        bit fault;
    } model_t;

    model_t ma, mb;
    int     mlut [32];

    prog_ctr_unit #(.PC_W(10), .PROG_LEN(1024), .LUT_AW(5)) u_big (
        .clk(clk), .start(start), .stall(stall), .branch_en(branch_en),
        .branch_taken(branch_taken), .branch_abs(branch_abs), .lut_idx(lut_idx),
        .rel_off(rel_off), .halt(halt), .lut_wen(lut_wen), .lut_waddr(lut_waddr),
        .lut_wdata(lut_wdata), .prog_ct(pc_a), .done(done_a), .pc_fault(fault_a)
    );

    prog_ctr_unit #(.PC_W(10), .PROG_LEN(16), .LUT_AW(5)) u_small (
        .clk(clk), .start(start), .stall(stall), .branch_en(branch_en),
        .branch_taken(branch_taken), .branch_abs(branch_abs), .lut_idx(lut_idx),
        .rel_off(rel_off), .halt(halt), .lut_wen(lut_wen), .lut_waddr(lut_waddr),
        .lut_wdata(lut_wdata), .prog_ct(pc_b), .done(done_b), .pc_fault(fault_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference: the architectural rules in plain integer arithmetic.
    function automatic model_t model_step(model_t m, int prog_len);
        int nxt;
        if (start) begin
            m.pc = 0; m.done = 0; m.fault = 0;
        end else if (!m.done && !stall) begin
            if (halt) begin
                m.done = 1;
            end else begin
                if (branch_en && branch_taken)
                    nxt = branch_abs ? mlut[lut_idx] : m.pc + int'($signed(rel_off));
                else
                    nxt = m.pc + 1;
                if (nxt < 0 || nxt >= prog_len) begin
                    m.done = 1; m.fault = 1;
                end else begin
                    m.pc = nxt;
                end
            end
        end
        return m;
    endfunction

    task automatic idle_inputs();
        start = 0; stall = 0; branch_en = 0; branch_taken = 0; branch_abs = 0;
        halt = 0; lut_wen = 0; lut_idx = '0; lut_waddr = '0; rel_off = '0; lut_wdata = '0;
    endtask

    // One clock: model advances on the edge, outputs compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        ma = model_step(ma, 1024);
        mb = model_step(mb, 16);
        if (lut_wen) mlut[lut_waddr] = int'(lut_wdata);
        #1;
        check("pc_a", int'(pc_a), ma.pc);
        check("done_a", int'(done_a), int'(ma.done));
        check("fault_a", int'(fault_a), int'(ma.fault));
        check("pc_b", int'(pc_b), mb.pc);
        check("done_b", int'(done_b), int'(mb.done));
        check("fault_b", int'(fault_b), int'(mb.fault));
    endtask

    task automatic restart();
        idle_inputs();
        start = 1;
        cycle();
        start = 0;
    endtask

    task automatic idles(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        ma = '{pc: 0, done: 0, fault: 0};
        mb = '{pc: 0, done: 0, fault: 0};
        idle_inputs();
        start = 1;
        // Load every LUT entry while held in reset so model and DUT agree.
        for (int i = 0; i < 32; i++) begin
            lut_wen = 1; lut_waddr = 5'(i); lut_wdata = 10'((i * 37) % 1024);
            cycle();
        end
        check("reset_pc", int'(pc_a), 0);
        check("reset_done", int'(done_a), 0);
        check("reset_fault", int'(fault_a), 0);

        // Sequential run 0..5
        idle_inputs();
        for (int i = 1; i <= 5; i++) begin
            cycle();
            check("seq_pc", int'(pc_a), i);
        end
        idles(5);
        check("at10", int'(pc_a), 10);

        // Relative back branch, not-taken branch, stall with LUT write
        branch_en = 1; branch_taken = 1; rel_off = 8'hFC;
        cycle();
        check("rel_back", int'(pc_a), 6);
        branch_en = 1; branch_taken = 0; rel_off = 8'd3;
        cycle();
        check("not_taken", int'(pc_a), 7);
        idle_inputs();
        stall = 1; lut_wen = 1; lut_waddr = 5'd3; lut_wdata = 10'd200;
        cycle();
        lut_wen = 0; branch_en = 1; branch_taken = 1; halt = 1;
        cycle();
        check("stall_pc", int'(pc_a), 7);
        check("stall_done", int'(done_a), 0);

        // Absolute branch, then write+branch same index in one cycle
        idle_inputs();
        branch_en = 1; branch_taken = 1; branch_abs = 1; lut_idx = 5'd3;
        cycle();
        check("abs_pc", int'(pc_a), 200);
        lut_wen = 1; lut_waddr = 5'd3; lut_wdata = 10'd50;
        cycle();
        check("abs_old_entry", int'(pc_a), 200);

        // Halt at 12, then hold for 10 cycles under noise
        restart();
        idles(12);
        halt = 1;
        cycle();
        check("halt_done", int'(done_a), 1);
        check("halt_pc", int'(pc_a), 12);
        for (int i = 0; i < 10; i++) begin
            halt = 1'($urandom); stall = 1'($urandom); branch_en = 1'($urandom);
            branch_taken = 1'($urandom); branch_abs = 1'($urandom);
            rel_off = 8'($urandom); lut_idx = 5'($urandom);
            cycle();
        end
        check("halt_hold_pc", int'(pc_a), 12);
        check("halt_hold_fault", int'(fault_a), 0);

        // Start while in DONE
        restart();
        check("start_done_pc", int'(pc_a), 0);
        check("start_done_done", int'(done_a), 0);

        // Relative branch below zero
        idles(2);
        branch_en = 1; branch_taken = 1; rel_off = 8'hFB;
        cycle();
        check("neg_fault", int'(fault_a), 1);
        check("neg_done", int'(done_a), 1);
        check("neg_pc", int'(pc_a), 2);

        // Increment past PROG_LEN-1 on the 16-entry instance
        restart();
        idles(15);
        check("small_at15", int'(pc_b), 15);
        idles(1);
        check("small_wrap_fault", int'(fault_b), 1);
        check("small_wrap_pc", int'(pc_b), 15);

        // Start mid-run at 40, LUT retained afterwards
        idles(24);
        check("at40", int'(pc_a), 40);
        restart();
        check("mid_start_pc", int'(pc_a), 0);
        check("mid_start_small_fault", int'(fault_b), 0);
        branch_en = 1; branch_taken = 1; branch_abs = 1; lut_idx = 5'd3;
        cycle();
        check("lut_retained", int'(pc_a), 50);

        // start and halt together: start wins
        idle_inputs();
        start = 1; halt = 1;
        cycle();
        idle_inputs();
        check("start_halt_done", int'(done_a), 0);
        cycle();
        check("start_halt_pc", int'(pc_a), 1);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            start = ($urandom_range(0, 39) == 0);
            stall = ($urandom_range(0, 4) == 0);
            halt = ($urandom_range(0, 59) == 0);
            branch_en = ($urandom_range(0, 2) == 0);
            branch_taken = 1'($urandom);
            branch_abs = 1'($urandom);
            lut_idx = 5'($urandom);
            rel_off = 8'($urandom);
            lut_wen = ($urandom_range(0, 3) == 0);
            lut_waddr = 5'($urandom);
            lut_wdata = $urandom_range(0, 1) ? 10'($urandom_range(0, 15)) : 10'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
